bin2bcd_seq: RTL and testbench

Sequential double-dabble converter that turns the 16-bit reaction-time count (milliseconds) into five BCD digits for the seven-segment decoders. It sits between the 16-bit reaction counter and the per-digit hex-to-7-seg decoders, and replaces the combinational converter with a small iterative datapath. It converts one value per start request and holds its result between conversions so the display stays stable.

---
 rtl/bin2bcd_seq.sv | 123 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 16-bit binary -> five BCD digits, one bit per clock.
// Latency: 16 clocks from the accepting start edge to digits/done; 17 clocks per conversion.
// Backpressure: none; start is ignored while busy, results hold until the next done.
// Optional leading-zero blank mask enabled by defining BIN2BCD_LZ_BLANK_EN.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [3:0]  bcd0,
  output logic [3:0]  bcd1,
  output logic [3:0]  bcd2,
  output logic [3:0]  bcd3,
  output logic [3:0]  bcd4,
  output logic [4:0]  blank
);

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state_q;
  logic [15:0] shreg_q;
  logic [19:0] scratch_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [19:0] bcd_q;

  logic [19:0] scratch_adj_d;
  logic [35:0] shifted_d;
  logic [19:0] scratch_d;
  logic [15:0] shreg_d;

  // One double-dabble step: add 3 to every nibble >= 5 (no inter-nibble carry), then shift the
  // whole {scratch, shreg} pair left so the binary MSB enters the scratch LSB.
  always_comb begin
    scratch_adj_d = scratch_q;
    for (int i = 0; i < 5; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        scratch_adj_d[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    shifted_d = {scratch_adj_d, shreg_q} << 1;
    scratch_d = shifted_d[35:16];
    shreg_d   = shifted_d[15:0];
  end

`ifdef BIN2BCD_LZ_BLANK_EN
  logic [4:0] blank_q;
  logic [4:0] blank_d;

  // Blank a digit when it and every more significant digit are zero; the units digit always shows.
  always_comb begin
    blank_d    = 5'b00000;
    blank_d[4] = (scratch_d[19:16] == 4'd0);
    blank_d[3] = blank_d[4] && (scratch_d[15:12] == 4'd0);
    blank_d[2] = blank_d[3] && (scratch_d[11:8] == 4'd0);
    blank_d[1] = blank_d[2] && (scratch_d[7:4] == 4'd0);
  end

  // Mask is registered with the digits so the display sees a consistent pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_q <= 5'b11110;
    end else if (state_q == CONV && cnt_q == 4'd15) begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  assign blank = 5'b00000;
`endif

  // Control FSM plus datapath registers; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= 16'd0;
      scratch_q <= 20'd0;
      cnt_q     <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= 20'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            shreg_q   <= bin;
            scratch_q <= 20'd0;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b1;
            state_q   <= CONV;
          end
        end
        CONV: begin
          scratch_q <= scratch_d;
          shreg_q   <= shreg_d;
          cnt_q     <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            // Sixteenth bit shifted in: publish result and free the converter.
            bcd_q   <= scratch_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd0 = bcd_q[3:0];
  assign bcd1 = bcd_q[7:4];
  assign bcd2 = bcd_q[11:8];
  assign bcd3 = bcd_q[15:12];
  assign bcd4 = bcd_q[19:16];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: reset, single, extremes, start-while-busy, back-to-back,
// and reset mid-conversion. Expected digits are written as hex literals of the BCD value.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [3:0]  bcd0, bcd1, bcd2, bcd3, bcd4;
  logic [4:0]  blank;

  int checks = 0;
  int errors = 0;

`ifdef BIN2BCD_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  bin2bcd_seq dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .bcd0 (bcd0),
    .bcd1 (bcd1),
    .bcd2 (bcd2),
    .bcd3 (bcd3),
    .bcd4 (bcd4),
    .blank(blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] digits();
    return {bcd4, bcd3, bcd2, bcd1, bcd0};
  endfunction

  function automatic logic [4:0] exp_blank(input logic [4:0] b);
    return LZ ? b : 5'b00000;
  endfunction

  // Launch one conversion (start for one clock) and wait for done, sampling on negedges.
  // lat = edges from accept to done (-1 on timeout), busy_cnt = cycles busy seen, both = busy&&done seen.
  task automatic run_conv(input logic [15:0] v, output int lat, output int busy_cnt, output bit both);
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    @(negedge clk);
    start = 1'b0;
    bin   = 16'hFFFF;
    lat = -1;
    busy_cnt = 0;
    both = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      if (busy && done) both = 1'b1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int ndone;
    rst = 1'b1;
    start = 1'b0;
    bin = 16'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl busy=%b done=%b required busy=0 done=0", busy, done);
    end
    checks++;
    if (digits() !== 20'h00000) begin
      errors++;
      $display("FAIL reset_digits got %h required 00000", digits());
    end
    checks++;
    if (blank !== exp_blank(5'b11110)) begin
      errors++;
      $display("FAIL reset_blank got %b required %b", blank, exp_blank(5'b11110));
    end
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL idle_no_done got %0d active cycles required 0", ndone);
    end
  endtask

  task automatic test_single();
    int lat, bc;
    bit both;
    run_conv(16'd1234, lat, bc, both);
    checks++;
    if (lat !== 16) begin
      errors++;
      $display("FAIL single_latency got %0d required 16", lat);
    end
    checks++;
    if (bc !== 16) begin
      errors++;
      $display("FAIL single_busy_cycles got %0d required 16", bc);
    end
    checks++;
    if (both !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_done_overlap both=%b busy=%b required 0", both, busy);
    end
    checks++;
    if (digits() !== 20'h01234) begin
      errors++;
      $display("FAIL single_digits got %h required 01234", digits());
    end
    checks++;
    if (blank !== exp_blank(5'b10000)) begin
      errors++;
      $display("FAIL single_blank got %b required %b", blank, exp_blank(5'b10000));
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL single_done_pulse got %b required 0", done);
    end
    bin = 16'd7;
    repeat (5) @(negedge clk);
    checks++;
    if (digits() !== 20'h01234) begin
      errors++;
      $display("FAIL single_hold got %h required 01234", digits());
    end
  endtask

  task automatic test_extremes();
    int lat, bc;
    bit both;
    run_conv(16'd65535, lat, bc, both);
    checks++;
    if (lat !== 16 || digits() !== 20'h65535) begin
      errors++;
      $display("FAIL max_digits lat=%0d got %h required lat=16 65535", lat, digits());
    end
    checks++;
    if (blank !== 5'b00000) begin
      errors++;
      $display("FAIL max_blank got %b required 00000", blank);
    end
    run_conv(16'd0, lat, bc, both);
    checks++;
    if (lat !== 16 || digits() !== 20'h00000) begin
      errors++;
      $display("FAIL zero_digits lat=%0d got %h required lat=16 00000", lat, digits());
    end
    checks++;
    if (blank !== exp_blank(5'b11110)) begin
      errors++;
      $display("FAIL zero_blank got %b required %b", blank, exp_blank(5'b11110));
    end
  endtask

  task automatic test_start_while_busy();
    int ndone, first;
    @(negedge clk);
    start = 1'b1;
    bin = 16'd500;
    @(negedge clk);          // after accepting edge E0
    start = 1'b0;
    ndone = 0;
    first = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        start = 1'b1;
        bin = 16'd999;
      end else if (k == 6) begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (ndone !== 1 || first !== 16) begin
      errors++;
      $display("FAIL busy_ignore_start dones=%0d at %0d required 1 at 16", ndone, first);
    end
    checks++;
    if (digits() !== 20'h00500) begin
      errors++;
      $display("FAIL busy_ignore_digits got %h required 00500", digits());
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [4];
    logic [19:0] expd [4];
    logic [4:0]  expb [4];
    int idx, extra;
    vals[0] = 16'd9;     expd[0] = 20'h00009; expb[0] = 5'b11110;
    vals[1] = 16'd10000; expd[1] = 20'h10000; expb[1] = 5'b00000;
    vals[2] = 16'd9;     expd[2] = 20'h00009; expb[2] = 5'b11110;
    vals[3] = 16'd10000; expd[3] = 20'h10000; expb[3] = 5'b00000;
    @(negedge clk);
    start = 1'b1;
    bin = vals[0];
    idx = 0;
    for (int t = 1; t <= 80 && idx < 4; t++) begin
      @(negedge clk);
      if (done) begin
        checks++;
        if (t !== 17 * (idx + 1)) begin
          errors++;
          $display("FAIL b2b_timing conv %0d got t=%0d required t=%0d", idx, t, 17 * (idx + 1));
        end
        checks++;
        if (digits() !== expd[idx] || blank !== exp_blank(expb[idx])) begin
          errors++;
          $display("FAIL b2b_result conv %0d got %h/%b required %h/%b", idx, digits(), blank,
                   expd[idx], exp_blank(expb[idx]));
        end
        idx++;
        if (idx < 4) bin = vals[idx];
        else start = 1'b0;
      end
    end
    start = 1'b0;
    extra = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++;
    if (idx !== 4 || extra !== 0) begin
      errors++;
      $display("FAIL b2b_count got %0d conversions and %0d extra required 4 and 0", idx, extra);
    end
  endtask

  task automatic test_reset_mid();
    int ndone, lat, bc;
    bit both;
    @(negedge clk);
    start = 1'b1;
    bin = 16'd4321;
    @(negedge clk);          // after E0
    start = 1'b0;
    repeat (8) @(posedge clk); // E8: eighth iteration
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || digits() !== 20'h00000 ||
        blank !== exp_blank(5'b11110)) begin
      errors++;
      $display("FAIL reset_mid_async busy=%b done=%b digits=%h blank=%b required 0 0 00000 %b",
               busy, done, digits(), blank, exp_blank(5'b11110));
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done got %0d active cycles required 0", ndone);
    end
    run_conv(16'd42, lat, bc, both);
    checks++;
    if (lat !== 16 || digits() !== 20'h00042 || blank !== exp_blank(5'b11100)) begin
      errors++;
      $display("FAIL reset_mid_restart lat=%0d got %h/%b required 16 00042/%b", lat, digits(),
               blank, exp_blank(5'b11100));
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bin = 16'd0;
    test_reset();
    test_single();
    test_extremes();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
